proc_ctrl: RTL
==============

# proc_ctrl

Control sequencer for the 16-bit bus-based processor. Each cycle it drives the select inputs of the bus multiplexer (`din_en`, `gout`, `rout`) and the load enables of R0–R7, A, G and IR. It fetches a 9-bit instruction from `din`, then steps through up to three execution time-steps (T1–T3). It pulses `done` on the final step of each instruction.

## Interface
Parameters:
- `RUN_LEVEL`, default 1. Selects how `run` is sampled in T0.
  - 1: an instruction starts whenever `run` is high in T0.
  - 0: an instruction starts only on a 0→1 edge of `run`, detected against a registered copy `run_q`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: start request.
- `din` in 9: instruction word (`din[8:6]`=III opcode, `din[5:3]`=XXX, `din[2:0]`=YYY); also sampled for the IR load.
- `ir_load` out 1: IR load enable.
- `din_en` out 1: bus select, drive `din` onto the bus.
- `gout` out 1: bus select, drive ALU result G onto the bus.
- `rout` out 3: bus select, register index.
- `r_in` out 8: one-hot register load enables for R0–R7.
- `a_in` out 1: A register load enable.
- `g_in` out 1: G register load enable.
- `alu_op` out 2: ALU operation; 00 add, 01 sub, 10 and, 11 xor.
- `done` out 1: one-cycle pulse in the last step of an instruction.

## Operation
- The state register holds T0..T3. The internal `ir[8:0]` is loaded from `din` when `ir_load` is high.
- All outputs are combinational from the state and `ir`, except `ir_load` in T0, which also depends on `run`.
- Default output values in every state: `din_en`=0, `gout`=0, `rout`=0, `r_in`=0, `a_in`=0, `g_in`=0, `alu_op`=00, `done`=0.
- T0: `ir_load` = start condition.
  - Start condition true: `ir` <= `din`, next state T1.
  - Otherwise: stay in T0.
- Opcode 000 `mv Rx,Ry`, in T1: `rout`=Y, `r_in[X]`=1, `done`=1, then T0.
- Opcode 001 `mvi Rx,#D`, in T1: `din_en`=1, `r_in[X]`=1, `done`=1, then T0. The immediate D must be present on `din` during T1.
- Opcodes 010 `add` and 011 `sub`:
  - T1: `rout`=X, `a_in`=1.
  - T2: `rout`=Y, `g_in`=1, `alu_op`=00 for add or 01 for sub.
  - T3: `gout`=1, `r_in[X]`=1, `done`=1, then T0.
- Opcodes 100 (and) and 101 (xor): see Configuration.
- Opcodes 110 and 111: NOP. T1 asserts `done` only, then T0.
- `r_in` always has at most one bit set. `din_en` and `gout` are never high together.
- `run` is ignored outside T0; dropping it mid-instruction has no effect.

## Timing
- Reset asserted (async):
  - State returns to T0 and `ir` clears to 0.
  - `run_q` clears to 0.
  - All outputs are 0, including `ir_load`, which is gated by `resetn`.
  - Reset in the middle of an instruction abandons it; no `done` pulse is produced.
- Latency from `ir` load, in cycles after the T0 edge:
  - mv, mvi, NOP: 1 cycle.
  - add, sub, and, xor: 3 cycles.
- Back-to-back instructions: with `RUN_LEVEL`=1 and `run` held high, the next T0 fetches immediately after `done`, with no idle cycle beyond T0 itself.
- With `RUN_LEVEL`=0:
  - `run_q` updates every cycle.
  - A `run` held high starts exactly one instruction; a new rising edge is needed to start another.

## Configuration
- `PROC_CTRL_LOGIC_EN` defined:
  - Opcode 100 = `and Rx,Ry` and opcode 101 = `xor Rx,Ry`.
  - Both use the add/sub T1–T3 sequence with `alu_op` 10 and 11 respectively.
- Undefined:
  - 100 and 101 decode as NOP: `done` in T1, no load enables.
  - `alu_op[1]` is tied to 0.

## Test plan
- Reset with `run`=1 held: all outputs 0 while `resetn`=0. On release, `ir_load`=1 in the first T0.
- `mvi R2,#0x1234`:
  - Instruction `din`=9'b001_010_000.
  - Next cycle: `din_en`=1, `r_in`=8'b0000_0100, `done`=1.
  - Following cycle: T0.
- `mv R5,R3` (9'b000_101_011): T1 gives `rout`=3, `r_in`=8'b0010_0000, `done`=1.
- `sub R1,R6` (9'b011_001_110):
  - T1: `rout`=1, `a_in`=1.
  - T2: `rout`=6, `g_in`=1, `alu_op`=01.
  - T3: `gout`=1, `r_in`=8'b0000_0010, `done`=1.
- `resetn` pulsed low during T2 of an add: state returns to T0, no `done` pulse, `ir`=0.
- Opcode 101:
  - Macro on: T2 `alu_op`=11, `done` in T3.
  - Macro off: `done` in T1, `r_in`=0.
  - `RUN_LEVEL`=0 with `run` held high for 10 cycles: exactly one `done` pulse.

Source files
------------

// File: rtl/proc_ctrl.sv
// Control sequencer for the 16-bit bus-based processor: fetch in T0, execute in T1..T3.
// Define PROC_CTRL_LOGIC_EN to decode opcodes 100/101 as and/xor; otherwise they are NOPs.
module proc_ctrl #(
  parameter int unsigned RUN_LEVEL = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic [8:0] din,
  output logic       ir_load,
  output logic       din_en,
  output logic       gout,
  output logic [2:0] rout,
  output logic [7:0] r_in,
  output logic       a_in,
  output logic       g_in,
  output logic [1:0] alu_op,
  output logic       done
);

  typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_t;

  state_t     state;
  logic [8:0] ir;
  logic       run_q;

  logic [2:0] opc;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_alu;
  logic [1:0] alu_sel;
  logic       start;

  assign opc = ir[8:6];
  assign rx  = ir[5:3];
  assign ry  = ir[2:0];

`ifdef PROC_CTRL_LOGIC_EN
  assign is_alu  = (opc == 3'b010) || (opc == 3'b011) || (opc == 3'b100) || (opc == 3'b101);
  assign alu_sel = {opc[2], opc[0]};
`else
  assign is_alu  = (opc == 3'b010) || (opc == 3'b011);
  assign alu_sel = {1'b0, opc[0]};
`endif

  // Edge mode needs run_q low in the previous cycle, so a held run starts only once.
  assign start = (RUN_LEVEL != 0) ? run : (run & ~run_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= StT0;
      ir    <= 9'd0;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      unique case (state)
        StT0: begin
          if (start) begin
            ir    <= din;
            state <= StT1;
          end
        end
        StT1:    state <= is_alu ? StT2 : StT0;
        StT2:    state <= StT3;
        StT3:    state <= StT0;
        default: state <= StT0;
      endcase
    end
  end

  always_comb begin
    ir_load = 1'b0;
    din_en  = 1'b0;
    gout    = 1'b0;
    rout    = 3'd0;
    r_in    = 8'd0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = 2'b00;
    done    = 1'b0;
    unique case (state)
      StT0: ir_load = resetn & start;
      StT1: begin
        if (is_alu) begin
          rout = rx;
          a_in = 1'b1;
        end else if (opc == 3'b000) begin
          rout = ry;
          r_in = 8'd1 << rx;
          done = 1'b1;
        end else if (opc == 3'b001) begin
          din_en = 1'b1;
          r_in   = 8'd1 << rx;
          done   = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      StT2: begin
        rout   = ry;
        g_in   = 1'b1;
        alu_op = alu_sel;
      end
      StT3: begin
        gout = 1'b1;
        r_in = 8'd1 << rx;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
